// File: rtl/cpu_pkg.sv
// Shared multicycle-CPU definitions: opcodes, funct codes, datapath select
// encodings, ALU operations, control-unit state encodings and the control word.
package cpu_pkg;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_LUI   = 6'h0F;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;

    localparam logic [5:0] FN_DIV = 6'h1A;
    localparam logic [5:0] FN_ADD = 6'h20;
    localparam logic [5:0] FN_SUB = 6'h22;
    localparam logic [5:0] FN_AND = 6'h24;
    localparam logic [5:0] FN_OR  = 6'h25;
    localparam logic [5:0] FN_SLT = 6'h2A;

    localparam logic [2:0] ALU_ADD = 3'b000;
    localparam logic [2:0] ALU_SUB = 3'b001;
    localparam logic [2:0] ALU_AND = 3'b010;
    localparam logic [2:0] ALU_OR  = 3'b011;
    localparam logic [2:0] ALU_SLT = 3'b111;

    localparam logic [1:0] SRCA_PC = 2'b00;
    localparam logic [1:0] SRCA_A  = 2'b10;

    localparam logic [1:0] SRCB_B       = 2'b00;
    localparam logic [1:0] SRCB_FOUR    = 2'b01;
    localparam logic [1:0] SRCB_IMM     = 2'b10;
    localparam logic [1:0] SRCB_IMM_SH2 = 2'b11;

    localparam logic [2:0] PCSRC_MDR        = 3'b000;
    localparam logic [2:0] PCSRC_ALU_RESULT = 3'b001;
    localparam logic [2:0] PCSRC_ALU_OUT    = 3'b010;
    localparam logic [2:0] PCSRC_JUMP       = 3'b011;

    localparam logic [2:0] IORD_PC      = 3'b000;
    localparam logic [2:0] IORD_ALU_OUT = 3'b001;
    localparam logic [2:0] IORD_EXC     = 3'b011;

    localparam logic [2:0] REGDST_RT = 3'b000;
    localparam logic [2:0] REGDST_RD = 3'b001;
    localparam logic [2:0] REGDST_SP = 3'b011;

    localparam logic [3:0] MEMTOREG_ALU_OUT = 4'b0000;
    localparam logic [3:0] MEMTOREG_MDR     = 4'b0001;
    localparam logic [3:0] MEMTOREG_LUI     = 4'b0101;
    localparam logic [3:0] MEMTOREG_SP_INIT = 4'b1000;

    localparam logic [1:0] EXC_CAUSE_OPCODE = 2'b00;
    localparam logic [1:0] EXC_CAUSE_OVF    = 2'b01;
    localparam logic [1:0] EXC_CAUSE_DIV0   = 2'b10;

    localparam logic [4:0] S_RESET      = 5'd0;
    localparam logic [4:0] S_FETCH      = 5'd1;
    localparam logic [4:0] S_FETCH_WAIT = 5'd2;
    localparam logic [4:0] S_FETCH_WB   = 5'd3;
    localparam logic [4:0] S_DECODE     = 5'd4;
    localparam logic [4:0] S_R_EXEC     = 5'd5;
    localparam logic [4:0] S_R_WB       = 5'd6;
    localparam logic [4:0] S_ADDI_EXEC  = 5'd7;
    localparam logic [4:0] S_ADDI_WB    = 5'd8;
    localparam logic [4:0] S_MEM_ADDR   = 5'd9;
    localparam logic [4:0] S_LW_READ    = 5'd10;
    localparam logic [4:0] S_LW_WAIT    = 5'd11;
    localparam logic [4:0] S_LW_MDR     = 5'd12;
    localparam logic [4:0] S_LW_WB      = 5'd13;
    localparam logic [4:0] S_SW_WRITE   = 5'd14;
    localparam logic [4:0] S_BEQ        = 5'd15;
    localparam logic [4:0] S_JUMP       = 5'd16;
    localparam logic [4:0] S_LUI        = 5'd17;
    localparam logic [4:0] S_DIV_START  = 5'd18;
    localparam logic [4:0] S_DIV_WAIT   = 5'd19;
    localparam logic [4:0] S_DIV_WB     = 5'd20;
    localparam logic [4:0] S_EXC_OPCODE = 5'd21;
    localparam logic [4:0] S_EXC_OVF    = 5'd22;
    localparam logic [4:0] S_EXC_DIV0   = 5'd23;
    localparam logic [4:0] S_EXC_READ   = 5'd24;
    localparam logic [4:0] S_EXC_WAIT   = 5'd25;
    localparam logic [4:0] S_EXC_MDR    = 5'd26;
    localparam logic [4:0] S_EXC_JUMP   = 5'd27;

    typedef struct packed {
        logic [1:0] aluSrcA;
        logic [1:0] aluSrcB;
        logic [2:0] pcSource;
        logic [2:0] regDst;
        logic [3:0] memToReg;
        logic [2:0] iord;
        logic [2:0] aluOp;
        logic [1:0] excCause;
        logic       pcWrite;
        logic       memWrite;
        logic       irWrite;
        logic       mdrWrite;
        logic       regWrite;
        logic       aluOutWrite;
        logic       epcWrite;
        logic       hiloWrite;
        logic       divStart;
    } ctrlWord_t;

    function automatic logic isAluFunct(input logic [5:0] f);
        return (f == FN_ADD) || (f == FN_SUB) || (f == FN_AND) ||
               (f == FN_OR)  || (f == FN_SLT);
    endfunction

    function automatic logic [2:0] functToAluOp(input logic [5:0] f);
        case (f)
            FN_SUB:  return ALU_SUB;
            FN_AND:  return ALU_AND;
            FN_OR:   return ALU_OR;
            FN_SLT:  return ALU_SLT;
            default: return ALU_ADD;
        endcase
    endfunction

endpackage

// File: rtl/control_unit.sv
// Moore-style multicycle control FSM: state register, next-state logic and
// control-word decode for fetch, ALU, memory, branch, divide and exceptions.
module control_unit
    import cpu_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic [5:0] opcode,
    input  logic [5:0] funct,
    input  logic       zero,
    input  logic       overflow,
    input  logic       div_done,
    input  logic       div_by_zero,
    output logic [1:0] CtrlALUSrcA,
    output logic [1:0] CtrlALUSrcB,
    output logic [2:0] CtrlPCSource,
    output logic [2:0] CtrlRegDst,
    output logic [3:0] CtrlMemtoReg,
    output logic [2:0] CtrlIord,
    output logic       PCWrite,
    output logic       MemWrite,
    output logic       IRWrite,
    output logic       MDRWrite,
    output logic       RegWrite,
    output logic       ALUOutWrite,
    output logic       EPCWrite,
    output logic       HILOWrite,
    output logic       DivStart,
    output logic [2:0] ALUOp,
    output logic [1:0] ExcCause
);

    logic [4:0] stateReg, stateNext;
    logic [1:0] excCauseReg, excCauseNext;
    logic [2:0] rAluOpReg, rAluOpNext;
    logic       ovfCheckReg, ovfCheckNext;
    ctrlWord_t  ctrl;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            stateReg    <= S_RESET;
            excCauseReg <= EXC_CAUSE_OPCODE;
            rAluOpReg   <= ALU_ADD;
            ovfCheckReg <= 1'b0;
        end else begin
            stateReg    <= stateNext;
            excCauseReg <= excCauseNext;
            rAluOpReg   <= rAluOpNext;
            ovfCheckReg <= ovfCheckNext;
        end
    end

    // R-type ALU op and overflow sensitivity are captured at decode so that
    // R_EXEC outputs depend on registered values only.
    always_comb begin
        stateNext    = stateReg;
        excCauseNext = excCauseReg;
        rAluOpNext   = rAluOpReg;
        ovfCheckNext = ovfCheckReg;
        case (stateReg)
            S_RESET:      stateNext = S_FETCH;
            S_FETCH:      stateNext = S_FETCH_WAIT;
            S_FETCH_WAIT: stateNext = S_FETCH_WB;
            S_FETCH_WB:   stateNext = S_DECODE;
            S_DECODE: begin
                case (opcode)
                    OP_RTYPE: begin
                        if (funct == FN_DIV) begin
                            stateNext = S_DIV_START;
                        end else if (isAluFunct(funct)) begin
                            stateNext    = S_R_EXEC;
                            rAluOpNext   = functToAluOp(funct);
                            ovfCheckNext = (funct == FN_ADD) || (funct == FN_SUB);
                        end else begin
                            stateNext    = S_EXC_OPCODE;
                            excCauseNext = EXC_CAUSE_OPCODE;
                        end
                    end
                    OP_ADDI:      stateNext = S_ADDI_EXEC;
                    OP_LW, OP_SW: stateNext = S_MEM_ADDR;
                    OP_BEQ:       stateNext = S_BEQ;
                    OP_J:         stateNext = S_JUMP;
                    OP_LUI:       stateNext = S_LUI;
                    default: begin
                        stateNext    = S_EXC_OPCODE;
                        excCauseNext = EXC_CAUSE_OPCODE;
                    end
                endcase
            end
            S_R_EXEC, S_ADDI_EXEC: begin
                if ((ovfCheckReg || stateReg == S_ADDI_EXEC) && overflow) begin
                    stateNext    = S_EXC_OVF;
                    excCauseNext = EXC_CAUSE_OVF;
                end else begin
                    stateNext = (stateReg == S_R_EXEC) ? S_R_WB : S_ADDI_WB;
                end
            end
            S_MEM_ADDR:   stateNext = (opcode == OP_SW) ? S_SW_WRITE : S_LW_READ;
            S_LW_READ:    stateNext = S_LW_WAIT;
            S_LW_WAIT:    stateNext = S_LW_MDR;
            S_LW_MDR:     stateNext = S_LW_WB;
            S_DIV_START:  stateNext = S_DIV_WAIT;
            S_DIV_WAIT: begin
                if (div_done) begin
                    if (div_by_zero) begin
                        stateNext    = S_EXC_DIV0;
                        excCauseNext = EXC_CAUSE_DIV0;
                    end else begin
                        stateNext = S_DIV_WB;
                    end
                end
            end
            S_EXC_OPCODE, S_EXC_OVF, S_EXC_DIV0: stateNext = S_EXC_READ;
            S_EXC_READ:   stateNext = S_EXC_WAIT;
            S_EXC_WAIT:   stateNext = S_EXC_MDR;
            S_EXC_MDR:    stateNext = S_EXC_JUMP;
            S_R_WB, S_ADDI_WB, S_LW_WB, S_SW_WRITE, S_BEQ, S_JUMP, S_LUI,
            S_DIV_WB, S_EXC_JUMP: stateNext = S_FETCH;
            default:      stateNext = S_RESET;
        endcase
    end

    always_comb begin
        ctrl = '0;
        case (stateReg)
            S_RESET: begin
                ctrl.regWrite = 1'b1;
                ctrl.regDst   = REGDST_SP;
                ctrl.memToReg = MEMTOREG_SP_INIT;
            end
            S_FETCH, S_FETCH_WAIT: ctrl.iord = IORD_PC;
            S_FETCH_WB: begin
                ctrl.aluSrcA  = SRCA_PC;
                ctrl.aluSrcB  = SRCB_FOUR;
                ctrl.aluOp    = ALU_ADD;
                ctrl.pcSource = PCSRC_ALU_RESULT;
                ctrl.irWrite  = 1'b1;
                ctrl.pcWrite  = 1'b1;
            end
            S_DECODE: begin
                ctrl.aluSrcA     = SRCA_PC;
                ctrl.aluSrcB     = SRCB_IMM_SH2;
                ctrl.aluOutWrite = 1'b1;
            end
            S_R_EXEC: begin
                ctrl.aluSrcA     = SRCA_A;
                ctrl.aluSrcB     = SRCB_B;
                ctrl.aluOp       = rAluOpReg;
                ctrl.aluOutWrite = 1'b1;
            end
            S_R_WB: begin
                ctrl.regDst   = REGDST_RD;
                ctrl.memToReg = MEMTOREG_ALU_OUT;
                ctrl.regWrite = 1'b1;
            end
            S_ADDI_EXEC, S_MEM_ADDR: begin
                ctrl.aluSrcA     = SRCA_A;
                ctrl.aluSrcB     = SRCB_IMM;
                ctrl.aluOutWrite = 1'b1;
            end
            S_ADDI_WB: begin
                ctrl.regDst   = REGDST_RT;
                ctrl.regWrite = 1'b1;
            end
            // Address is held through the latency cycle so the memory sees a stable address.
            S_LW_READ, S_LW_WAIT: ctrl.iord = IORD_ALU_OUT;
            S_LW_MDR: ctrl.mdrWrite = 1'b1;
            S_LW_WB: begin
                ctrl.memToReg = MEMTOREG_MDR;
                ctrl.regDst   = REGDST_RT;
                ctrl.regWrite = 1'b1;
            end
            S_SW_WRITE: begin
                ctrl.iord     = IORD_ALU_OUT;
                ctrl.memWrite = 1'b1;
            end
            // Taken-branch write is qualified by the compare result of this same cycle.
            S_BEQ: begin
                ctrl.aluSrcA  = SRCA_A;
                ctrl.aluSrcB  = SRCB_B;
                ctrl.aluOp    = ALU_SUB;
                ctrl.pcSource = PCSRC_ALU_OUT;
                ctrl.pcWrite  = zero;
            end
            S_JUMP: begin
                ctrl.pcSource = PCSRC_JUMP;
                ctrl.pcWrite  = 1'b1;
            end
            S_LUI: begin
                ctrl.memToReg = MEMTOREG_LUI;
                ctrl.regDst   = REGDST_RT;
                ctrl.regWrite = 1'b1;
            end
            S_DIV_START: ctrl.divStart  = 1'b1;
            S_DIV_WB:    ctrl.hiloWrite = 1'b1;
            S_EXC_OPCODE, S_EXC_OVF, S_EXC_DIV0: begin
                ctrl.aluSrcA  = SRCA_PC;
                ctrl.aluSrcB  = SRCB_FOUR;
                ctrl.aluOp    = ALU_SUB;
                ctrl.epcWrite = 1'b1;
                ctrl.excCause = excCauseReg;
            end
            S_EXC_READ, S_EXC_WAIT: begin
                ctrl.iord     = IORD_EXC;
                ctrl.excCause = excCauseReg;
            end
            S_EXC_MDR: begin
                ctrl.mdrWrite = 1'b1;
                ctrl.excCause = excCauseReg;
            end
            S_EXC_JUMP: begin
                ctrl.pcSource = PCSRC_MDR;
                ctrl.pcWrite  = 1'b1;
                ctrl.excCause = excCauseReg;
            end
            default: ;
        endcase
        // RESET state decodes the R29 init write, which must stay quiet while reset is held.
        if (!reset) begin
            ctrl = '0;
        end
    end

    assign CtrlALUSrcA  = ctrl.aluSrcA;
    assign CtrlALUSrcB  = ctrl.aluSrcB;
    assign CtrlPCSource = ctrl.pcSource;
    assign CtrlRegDst   = ctrl.regDst;
    assign CtrlMemtoReg = ctrl.memToReg;
    assign CtrlIord     = ctrl.iord;
    assign ALUOp        = ctrl.aluOp;
    assign ExcCause     = ctrl.excCause;
    assign PCWrite      = ctrl.pcWrite;
    assign MemWrite     = ctrl.memWrite;
    assign IRWrite      = ctrl.irWrite;
    assign MDRWrite     = ctrl.mdrWrite;
    assign RegWrite     = ctrl.regWrite;
    assign ALUOutWrite  = ctrl.aluOutWrite;
    assign EPCWrite     = ctrl.epcWrite;
    assign HILOWrite    = ctrl.hiloWrite;
    assign DivStart     = ctrl.divStart;

endmodule

// File: tb/tb_control_unit.sv
// Scoreboard bench for control_unit: per-cycle expected control words are
// queued as each instruction is driven and compared on the falling edge.
`timescale 1ns/1ps
module tb_control_unit;

    logic       clk = 1'b0;
    logic       reset;
    logic [5:0] opcode, funct;
    logic       zero, overflow, div_done, div_by_zero;
    logic [1:0] CtrlALUSrcA, CtrlALUSrcB, ExcCause;
    logic [2:0] CtrlPCSource, CtrlRegDst, CtrlIord, ALUOp;
    logic [3:0] CtrlMemtoReg;
    logic       PCWrite, MemWrite, IRWrite, MDRWrite, RegWrite;
    logic       ALUOutWrite, EPCWrite, HILOWrite, DivStart;

    always #5 clk = ~clk;

    control_unit dut (
        .clk(clk), .reset(reset), .opcode(opcode), .funct(funct), .zero(zero),
        .overflow(overflow), .div_done(div_done), .div_by_zero(div_by_zero),
        .CtrlALUSrcA(CtrlALUSrcA), .CtrlALUSrcB(CtrlALUSrcB), .CtrlPCSource(CtrlPCSource),
        .CtrlRegDst(CtrlRegDst), .CtrlMemtoReg(CtrlMemtoReg), .CtrlIord(CtrlIord),
        .PCWrite(PCWrite), .MemWrite(MemWrite), .IRWrite(IRWrite), .MDRWrite(MDRWrite),
        .RegWrite(RegWrite), .ALUOutWrite(ALUOutWrite), .EPCWrite(EPCWrite),
        .HILOWrite(HILOWrite), .DivStart(DivStart), .ALUOp(ALUOp), .ExcCause(ExcCause)
    );

    typedef struct packed {
        logic [1:0] srcA;
        logic [1:0] srcB;
        logic [2:0] pcSrc;
        logic [2:0] regDst;
        logic [3:0] memToReg;
        logic [2:0] iord;
        logic [2:0] aluOp;
        logic [1:0] exc;
        logic pcWrite, memWrite, irWrite, mdrWrite, regWrite;
        logic aluOutWrite, epcWrite, hiloWrite, divStart;
    } obs_t;

    obs_t obs;
    assign obs = {CtrlALUSrcA, CtrlALUSrcB, CtrlPCSource, CtrlRegDst, CtrlMemtoReg,
                  CtrlIord, ALUOp, ExcCause, PCWrite, MemWrite, IRWrite, MDRWrite,
                  RegWrite, ALUOutWrite, EPCWrite, HILOWrite, DivStart};

    int    total = 0;
    int    bad   = 0;
    obs_t  expQ[$];
    string tagQ[$];

    task automatic checkVal(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: observed=%h expected=%h", tag, got, exp);
        end
    endtask

    always @(negedge clk) begin : monitor
        obs_t  e;
        string t;
        if (expQ.size() > 0) begin
            e = expQ.pop_front();
            t = tagQ.pop_front();
            checkVal(t, {1'b0, obs}, {1'b0, e});
        end
    end

    // Expected control words, straight from the select/strobe tables.
    function automatic obs_t eIdle();
        obs_t e = '0;
        return e;
    endfunction
    function automatic obs_t eReset();
        obs_t e = '0;
        e.regWrite = 1'b1; e.regDst = 3'b011; e.memToReg = 4'b1000;
        return e;
    endfunction
    function automatic obs_t eFetchWb();
        obs_t e = '0;
        e.srcB = 2'b01; e.pcSrc = 3'b001; e.irWrite = 1'b1; e.pcWrite = 1'b1;
        return e;
    endfunction
    function automatic obs_t eDecode();
        obs_t e = '0;
        e.srcB = 2'b11; e.aluOutWrite = 1'b1;
        return e;
    endfunction
    function automatic obs_t eAluA(input logic [1:0] srcB, input logic [2:0] op);
        obs_t e = '0;
        e.srcA = 2'b10; e.srcB = srcB; e.aluOp = op; e.aluOutWrite = 1'b1;
        return e;
    endfunction
    function automatic obs_t eRegWb(input logic [2:0] dst, input logic [3:0] m2r);
        obs_t e = '0;
        e.regDst = dst; e.memToReg = m2r; e.regWrite = 1'b1;
        return e;
    endfunction
    function automatic obs_t eIord(input logic [2:0] iord, input logic [1:0] exc, input logic mw);
        obs_t e = '0;
        e.iord = iord; e.exc = exc; e.memWrite = mw;
        return e;
    endfunction
    function automatic obs_t eMdr(input logic [1:0] exc);
        obs_t e = '0;
        e.mdrWrite = 1'b1; e.exc = exc;
        return e;
    endfunction
    function automatic obs_t ePc(input logic [2:0] src, input logic wr, input logic [1:0] exc);
        obs_t e = '0;
        e.pcSrc = src; e.pcWrite = wr; e.exc = exc;
        return e;
    endfunction
    function automatic obs_t eBeq(input logic taken);
        obs_t e = '0;
        e.srcA = 2'b10; e.aluOp = 3'b001; e.pcSrc = 3'b010; e.pcWrite = taken;
        return e;
    endfunction
    function automatic obs_t eExcEntry(input logic [1:0] exc);
        obs_t e = '0;
        e.srcB = 2'b01; e.aluOp = 3'b001; e.epcWrite = 1'b1; e.exc = exc;
        return e;
    endfunction
    function automatic obs_t eStrobe(input logic hilo, input logic ds);
        obs_t e = '0;
        e.hiloWrite = hilo; e.divStart = ds;
        return e;
    endfunction

    task automatic cyc(input obs_t e, input string tag);
        expQ.push_back(e);
        tagQ.push_back(tag);
        @(posedge clk);
        #1;
    endtask

    task automatic prefix(input string n);
        cyc(eIdle(),    {n, ".fetch"});
        cyc(eIdle(),    {n, ".fwait"});
        cyc(eFetchWb(), {n, ".fwb"});
        cyc(eDecode(),  {n, ".decode"});
    endtask

    task automatic excSeq(input logic [1:0] cause, input string n);
        cyc(eExcEntry(cause),              {n, ".excEntry"});
        cyc(eIord(3'b011, cause, 1'b0),    {n, ".excRead"});
        cyc(eIord(3'b011, cause, 1'b0),    {n, ".excWait"});
        cyc(eMdr(cause),                   {n, ".excMdr"});
        cyc(ePc(3'b000, 1'b1, cause),      {n, ".excJump"});
    endtask

    task automatic rInstr(input logic [5:0] f, input logic [2:0] op, input logic ovf,
                          input logic expExc, input string n);
        opcode = 6'h00; funct = f;
        prefix(n);
        overflow = ovf;
        cyc(eAluA(2'b00, op), {n, ".rexec"});
        overflow = 1'b0;
        if (expExc) excSeq(2'b01, n);
        else        cyc(eRegWb(3'b001, 4'b0000), {n, ".rwb"});
        $display("instr %s issued", n);
    endtask

    task automatic addiInstr(input logic ovf, input string n);
        opcode = 6'h08; funct = 6'h00;
        prefix(n);
        overflow = ovf;
        cyc(eAluA(2'b10, 3'b000), {n, ".exec"});
        overflow = 1'b0;
        if (ovf) excSeq(2'b01, n);
        else     cyc(eRegWb(3'b000, 4'b0000), {n, ".wb"});
        $display("instr %s issued", n);
    endtask

    task automatic memInstr(input logic isStore, input string n);
        opcode = isStore ? 6'h2B : 6'h23; funct = 6'h00;
        prefix(n);
        cyc(eAluA(2'b10, 3'b000), {n, ".addr"});
        if (isStore) begin
            cyc(eIord(3'b001, 2'b00, 1'b1), {n, ".write"});
        end else begin
            cyc(eIord(3'b001, 2'b00, 1'b0), {n, ".read"});
            cyc(eIord(3'b001, 2'b00, 1'b0), {n, ".wait"});
            cyc(eMdr(2'b00),                {n, ".mdr"});
            cyc(eRegWb(3'b000, 4'b0001),    {n, ".wb"});
        end
        $display("instr %s issued", n);
    endtask

    task automatic divInstr(input int waitCycles, input logic dz, input string n);
        opcode = 6'h00; funct = 6'h1A;
        prefix(n);
        cyc(eStrobe(1'b0, 1'b1), {n, ".start"});
        for (int i = 1; i <= waitCycles; i++) begin
            if (i == waitCycles) begin
                div_done = 1'b1; div_by_zero = dz;
            end
            cyc(eIdle(), {n, ".wait"});
        end
        div_done = 1'b0; div_by_zero = 1'b0;
        if (dz) excSeq(2'b10, n);
        else    cyc(eStrobe(1'b1, 1'b0), {n, ".hilo"});
        $display("instr %s issued", n);
    endtask

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        reset = 1'b0; opcode = 6'h00; funct = 6'h00;
        zero = 1'b0; overflow = 1'b0; div_done = 1'b0; div_by_zero = 1'b0;
        @(posedge clk); #1;
        cyc(eIdle(), "rst.held");
        cyc(eIdle(), "rst.held");
        reset = 1'b1;
        cyc(eReset(), "rst.init");

        rInstr(6'h20, 3'b000, 1'b0, 1'b0, "add");
        rInstr(6'h20, 3'b000, 1'b1, 1'b1, "addOvf");
        rInstr(6'h22, 3'b001, 1'b1, 1'b1, "subOvf");
        rInstr(6'h24, 3'b010, 1'b0, 1'b0, "and");
        rInstr(6'h25, 3'b011, 1'b1, 1'b0, "orOvfIgnored");
        rInstr(6'h2A, 3'b111, 1'b0, 1'b0, "slt");
        addiInstr(1'b0, "addi");
        addiInstr(1'b1, "addiOvf");
        memInstr(1'b0, "lw");
        memInstr(1'b1, "sw");

        opcode = 6'h04; zero = 1'b1;
        prefix("beqTaken");
        cyc(eBeq(1'b1), "beqTaken.beq");
        opcode = 6'h04; zero = 1'b0;
        prefix("beqNot");
        cyc(eBeq(1'b0), "beqNot.beq");
        $display("instr beq pair issued");

        opcode = 6'h02;
        prefix("j");
        cyc(ePc(3'b011, 1'b1, 2'b00), "j.jump");
        opcode = 6'h0F;
        prefix("lui");
        cyc(eRegWb(3'b000, 4'b0101), "lui.wb");
        $display("instr j/lui issued");

        divInstr(32, 1'b0, "div");
        divInstr(32, 1'b1, "divZero");
        divInstr(1, 1'b0, "divFast");

        opcode = 6'h3F;
        prefix("badOp");
        excSeq(2'b00, "badOp");
        opcode = 6'h00; funct = 6'h00;
        prefix("badFunct");
        excSeq(2'b00, "badFunct");
        $display("instr illegal pair issued");

        // Reset asserted in the middle of a divide wait must clear outputs at once.
        opcode = 6'h00; funct = 6'h1A;
        prefix("divAbort");
        cyc(eStrobe(1'b0, 1'b1), "divAbort.start");
        cyc(eIdle(), "divAbort.wait");
        cyc(eIdle(), "divAbort.wait");
        #2 reset = 1'b0;
        #1 checkVal("divAbort.asyncClear", {1'b0, obs}, 32'd0);
        cyc(eIdle(), "divAbort.held");
        cyc(eIdle(), "divAbort.held");
        reset = 1'b1;
        div_done = 1'b1;
        cyc(eReset(), "divAbort.init");
        div_done = 1'b0;
        rInstr(6'h22, 3'b001, 1'b0, 1'b0, "subAfterAbort");

        checkVal("queue.drain", expQ.size(), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/control_unit.md
CONTROL_UNIT -- requirements
Module: control_unit

Interface
REQ-001 SHALL have ports: clk  in  1  system clock, rising-edge.
REQ-002 SHALL have ports: reset  in  1  asynchronous, active-low reset.
REQ-003 SHALL have inputs: opcode 6, funct 6, zero 1, overflow 1, div_done 1, div_by_zero 1.
REQ-004 SHALL have mux-select outputs: CtrlALUSrcA 2, CtrlALUSrcB 2, CtrlPCSource 3, CtrlRegDst 3, CtrlMemtoReg 4, CtrlIord 3.
REQ-005 SHALL have 1-bit strobe outputs: PCWrite, MemWrite, IRWrite, MDRWrite, RegWrite, ALUOutWrite, EPCWrite, HILOWrite, DivStart.
REQ-006 SHALL have outputs ALUOp 3 (000 add, 001 sub, 010 and, 011 or, 111 slt) and ExcCause 2 (00 opcode, 01 overflow, 10 div0).
REQ-007 SHALL use select encodings: ALUSrcA 00 PC, 10 A. ALUSrcB 00 B, 01 const 4, 10 sext imm, 11 sext imm<<2. PCSource 000 MDR, 001 ALU_result, 010 ALU_out, 011 jump target. Iord 000 PC, 001 ALU_out, 011 exception vector (253+ExcCause). RegDst 000 rt, 001 rd, 011 const 29. MemtoReg 0000 ALU_out, 0001 MDR, 0101 imm<<16, 1000 const 227.

Function
REQ-008 SHALL be a Moore FSM; all outputs decode from the registered state only.
REQ-009 SHALL drive every strobe 0, every select 0 and ALUOp add in any state not explicitly asserting them.
REQ-010 SHALL sequence FETCH (Iord PC) -> FETCH_WAIT (one memory latency cycle) -> FETCH_WB (IRWrite, PC<=PC+4 via ALU_result, PCWrite) -> DECODE (ALUOut<=PC+sext imm<<2).
REQ-011 SHALL decode: R-type opcode 0x00 funct add 0x20/sub 0x22/and 0x24/or 0x25/slt 0x2A -> R_EXEC -> R_WB (RegDst rd, MemtoReg ALU_out, RegWrite) -> FETCH.
REQ-012 SHALL handle addi 0x08: ADDI_EXEC (A+sext imm, ALUOutWrite) -> ADDI_WB (RegDst rt) -> FETCH.
REQ-013 SHALL handle lw 0x23: MEM_ADDR -> LW_READ (Iord ALU_out) -> LW_WAIT -> LW_MDR (MDRWrite) -> LW_WB (MemtoReg MDR, RegDst rt) -> FETCH; sw 0x2B: MEM_ADDR -> SW_WRITE (Iord ALU_out, MemWrite one cycle) -> FETCH.
REQ-014 SHALL handle beq 0x04: BEQ state computes A-B; PCWrite with PCSource ALU_out only when zero=1; one cycle.
REQ-015 SHALL handle j 0x02: PCSource jump target, PCWrite, one cycle; lui 0x0F: MemtoReg imm<<16, RegDst rt, RegWrite, one cycle.
REQ-016 SHALL handle div (opcode 0, funct 0x1A): assert DivStart exactly one cycle, wait in DIV_WAIT until div_done; if div_by_zero at div_done go to EXC_DIV0, else HILOWrite one cycle -> FETCH.
REQ-017 SHALL, if overflow=1 during R_EXEC (add/sub) or ADDI_EXEC, suppress RegWrite and enter EXC_OVF.
REQ-018 SHALL route any other opcode/funct from DECODE to EXC_OPCODE.
REQ-019 SHALL sequence exceptions: EXC_x (ALU PC-4 into EPC, EPCWrite, ExcCause set) -> EXC_READ (Iord vector) -> EXC_WAIT -> EXC_MDR (MDRWrite) -> EXC_JUMP (PCSource MDR, PCWrite) -> FETCH.
REQ-020 SHALL hold ExcCause stable from EXC_x through EXC_JUMP.
REQ-021 SHALL give overflow priority over div_done/zero; only sampled in the listed states.

Reset
REQ-022 SHALL, while reset=0, force state RESET, all strobes 0, selects 0, asynchronously.
REQ-023 SHALL, in RESET after release, perform one cycle RegWrite with RegDst 011, MemtoReg 1000 (R29<=227) and PCWrite of 0, then FETCH.
REQ-024 SHALL abandon any in-flight instruction, including DIV_WAIT, on reset assertion; DivStart SHALL not reassert.

Structure
REQ-025 SHALL take opcodes, funct codes, select encodings, ALUOp codes and state enumeration from a shared package cpu_pkg.
REQ-026 SHALL be a single module; state register and output decode in the same file, no sub-modules.

Verification
REQ-027 Release reset -> cycle 1 RegWrite=1, RegDst=011, MemtoReg=1000; cycle 2 FETCH with Iord=000.
REQ-028 IR add, overflow=0 -> RegWrite=1 in R_WB, RegDst=001, 6 cycles total FETCH-to-FETCH; with overflow=1 -> no RegWrite, EPCWrite=1, ExcCause=01.
REQ-029 IR lw -> MDRWrite exactly once, RegWrite in LW_WB with MemtoReg=0001; IR sw -> MemWrite high exactly one cycle with Iord=001.
REQ-030 IR beq, zero=1 -> PCWrite=1, PCSource=010; zero=0 -> PCWrite=0 in BEQ.
REQ-031 IR div, div_done after 32 cycles, div_by_zero=0 -> DivStart single pulse, HILOWrite once; div_by_zero=1 -> ExcCause=10, Iord=011.
REQ-032 IR opcode 0x3F -> EXC_OPCODE path, PCWrite with PCSource=000 in EXC_JUMP; assert reset mid-DIV_WAIT -> all outputs 0 immediately.
